s6_multiboot_ctrl: RTL and testbench

Sequencer that reboots the Spartan-6 into a selected flash image by issuing the IPROG command stream through the ICAP primitive. It sits in the ICAP clock domain (≤20 MHz) between the settings bus and the `ICAP_SPARTAN6` port. It replaces host-driven word-by-word ICAP writes with a single guarded trigger.

---
 rtl/s6_multiboot_ctrl_if.sv | 22 ++
 rtl/s6_multiboot_ctrl.sv | 145 ++++++++++++++
 tb/tb_s6_multiboot_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/s6_multiboot_ctrl_if.sv
// rtl/s6_multiboot_ctrl_if.sv - settings bus and ICAP port bundle for the multiboot sequencer
interface s6_multiboot_ctrl_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        icap_busy;
    logic        icap_ce_n;
    logic        icap_write_n;
    logic [15:0] icap_i;
    logic        busy;
    logic        done;

    modport slave (
        input  set_stb, set_addr, set_data, icap_busy,
        output icap_ce_n, icap_write_n, icap_i, busy, done
    );

    modport master (
        output set_stb, set_addr, set_data, icap_busy,
        input  icap_ce_n, icap_write_n, icap_i, busy, done
    );
endinterface

// File: rtl/s6_multiboot_ctrl.sv
// rtl/s6_multiboot_ctrl.sv - guarded IPROG sequencer driving the Spartan-6 ICAP port
module s6_multiboot_ctrl #(
    parameter int unsigned SR_BASE       = 0,
    parameter logic [7:0]  SPI_RD_OPCODE = 8'h0B,
    parameter bit          BITSWAP       = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    s6_multiboot_ctrl_if.slave bus
);
    localparam logic [7:0] ADDR_MB   = 8'(SR_BASE);
    localparam logic [7:0] ADDR_GD   = 8'(SR_BASE + 32'd1);
    localparam logic [7:0] ADDR_TRIG = 8'(SR_BASE + 32'd2);
    localparam logic [3:0] LAST_IDX  = 4'd13;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_HOLD, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] mb_addr_q, mb_addr_d;
    logic [23:0] gd_addr_q, gd_addr_d;
    logic [23:0] mb_sh_q, mb_sh_d;
    logic [23:0] gd_sh_q, gd_sh_d;
    logic        ce_n_q, ce_n_d;
    logic        write_n_q, write_n_d;
    logic [15:0] icap_i_q, icap_i_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        trig;
    logic        sending;
    logic [15:0] word;

    function automatic logic [15:0] iprog_word(input logic [3:0] idx,
                                               input logic [23:0] m,
                                               input logic [23:0] g);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'hFFFF;
            4'd1:    w = 16'hAA99;
            4'd2:    w = 16'h5566;
            4'd3:    w = 16'h3261;
            4'd4:    w = m[15:0];
            4'd5:    w = 16'h3281;
            4'd6:    w = {SPI_RD_OPCODE, m[23:16]};
            4'd7:    w = 16'h32A1;
            4'd8:    w = g[15:0];
            4'd9:    w = 16'h32C1;
            4'd10:   w = {SPI_RD_OPCODE, g[23:16]};
            4'd11:   w = 16'h30A1;
            4'd12:   w = 16'h000E;
            4'd13:   w = 16'h2000;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    function automatic logic [15:0] byte_rev(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8+i]   = w[15-i];
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mb_addr_d = mb_addr_q;
        gd_addr_d = gd_addr_q;
        mb_sh_d   = mb_sh_q;
        gd_sh_d   = gd_sh_q;

        trig = bus.set_stb && (bus.set_addr == ADDR_TRIG) && (bus.set_data[31:16] == 16'hB007);
        if (bus.set_stb && bus.set_addr == ADDR_MB) mb_addr_d = bus.set_data[23:0];
        if (bus.set_stb && bus.set_addr == ADDR_GD) gd_addr_d = bus.set_data[23:0];

        case (state_q)
            ST_IDLE: begin
                // Shadows take the pre-write register values so a same-cycle update misses this run
                if (trig) begin
                    state_d = ST_SEND;
                    idx_d   = 4'd0;
                    mb_sh_d = mb_addr_q;
                    gd_sh_d = gd_addr_q;
                end
            end
            ST_SEND, ST_HOLD: begin
                if (bus.icap_busy) begin
                    state_d = ST_HOLD;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SEND;
                    idx_d   = 4'(idx_q + 4'd1);
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed from the next state so every port comes straight from a flop
        sending   = (state_d == ST_SEND) || (state_d == ST_HOLD);
        word      = iprog_word(idx_d, mb_sh_d, gd_sh_d);
        ce_n_d    = !sending;
        write_n_d = !sending;
        busy_d    = sending;
        done_d    = (state_d == ST_DONE);
        icap_i_d  = sending ? (BITSWAP ? byte_rev(word) : word) : 16'h0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            mb_addr_q <= 24'd0;
            gd_addr_q <= 24'd0;
            mb_sh_q   <= 24'd0;
            gd_sh_q   <= 24'd0;
            ce_n_q    <= 1'b1;
            write_n_q <= 1'b1;
            icap_i_q  <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mb_addr_q <= mb_addr_d;
            gd_addr_q <= gd_addr_d;
            mb_sh_q   <= mb_sh_d;
            gd_sh_q   <= gd_sh_d;
            ce_n_q    <= ce_n_d;
            write_n_q <= write_n_d;
            icap_i_q  <= icap_i_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.icap_ce_n    = ce_n_q;
    assign bus.icap_write_n = write_n_q;
    assign bus.icap_i       = icap_i_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_s6_multiboot_ctrl.sv
// tb/tb_s6_multiboot_ctrl.sv - self-checking bench for s6_multiboot_ctrl, both bit orders side by side
module tb_s6_multiboot_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    s6_multiboot_ctrl_if bus0 ();
    s6_multiboot_ctrl_if bus1 ();

    assign bus1.set_stb   = bus0.set_stb;
    assign bus1.set_addr  = bus0.set_addr;
    assign bus1.set_data  = bus0.set_data;
    assign bus1.icap_busy = bus0.icap_busy;

    s6_multiboot_ctrl #(.SR_BASE(0), .SPI_RD_OPCODE(8'h0B), .BITSWAP(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    s6_multiboot_ctrl #(.SR_BASE(0), .SPI_RD_OPCODE(8'h0B), .BITSWAP(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] obs0 [14];
    logic [15:0] obs1 [14];

    function automatic logic [15:0] ref_word(input int k, input logic [23:0] m,
                                             input logic [23:0] g, input bit swap);
        logic [15:0] list [14];
        logic [15:0] w;
        logic [15:0] r;
        list = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, m[15:0], 16'h3281,
                 {8'h0B, m[23:16]}, 16'h32A1, g[15:0], 16'h32C1, {8'h0B, g[23:16]},
                 16'h30A1, 16'h000E, 16'h2000};
        w = list[k];
        if (!swap) return w;
        for (int b = 0; b < 16; b++) r[(b / 8) * 8 + (7 - b % 8)] = w[b];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        chk({tag, "_ce0"}, 32'(bus0.icap_ce_n), 32'd1);
        chk({tag, "_wr0"}, 32'(bus0.icap_write_n), 32'd1);
        chk({tag, "_i0"}, 32'(bus0.icap_i), 32'd0);
        chk({tag, "_busy0"}, 32'(bus0.busy), 32'd0);
        chk({tag, "_done0"}, 32'(bus0.done), 32'(exp_done));
        chk({tag, "_ce1"}, 32'(bus1.icap_ce_n), 32'd1);
        chk({tag, "_i1"}, 32'(bus1.icap_i), 32'd0);
        chk({tag, "_busy1"}, 32'(bus1.busy), 32'd0);
        chk({tag, "_done1"}, 32'(bus1.done), 32'(exp_done));
    endtask

    task automatic write(input logic [7:0] addr, input logic [31:0] data);
        bus0.set_stb  = 1'b1;
        bus0.set_addr = addr;
        bus0.set_data = data;
        step();
        bus0.set_stb  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_idle("reset", 1'b0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic run_seq(input string tag, input logic [23:0] m, input logic [23:0] g,
                           input int hold_word, input int hold_len,
                           input int inject_at, input int abort_at);
        int k;
        int holds;
        int cyc;
        write(8'd0, {8'($urandom), m});
        write(8'd1, {8'($urandom), g});
        write(8'($urandom_range(3, 255)), $urandom);
        bus0.set_stb  = 1'b1;
        bus0.set_addr = 8'd2;
        bus0.set_data = {16'hB007, 16'($urandom)};
        step();
        bus0.set_stb = 1'b0;
        k = 0;
        holds = hold_len;
        cyc = 0;
        while (k < 14 && cyc < 40) begin
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_idle({tag, "_abort"}, 1'b0);
                bus0.icap_busy = 1'b0;
                step();
                reset_n = 1'b1;
                return;
            end
            chk({tag, "_ce0"}, 32'(bus0.icap_ce_n), 32'd0);
            chk({tag, "_wr0"}, 32'(bus0.icap_write_n), 32'd0);
            chk({tag, "_busy0"}, 32'(bus0.busy), 32'd1);
            chk({tag, "_done0"}, 32'(bus0.done), 32'd0);
            chk({tag, "_word0"}, 32'(bus0.icap_i), 32'(ref_word(k, m, g, 1'b0)));
            chk({tag, "_ce1"}, 32'(bus1.icap_ce_n), 32'd0);
            chk({tag, "_word1"}, 32'(bus1.icap_i), 32'(ref_word(k, m, g, 1'b1)));
            bus0.set_stb = 1'b0;
            if (inject_at >= 0 && cyc == inject_at) begin
                bus0.set_stb  = 1'b1;
                bus0.set_addr = 8'd0;
                bus0.set_data = $urandom;
            end else if (inject_at >= 0 && cyc == inject_at + 1) begin
                bus0.set_stb  = 1'b1;
                bus0.set_addr = 8'd2;
                bus0.set_data = 32'hB0070000;
            end
            if (k == hold_word && holds > 0) begin
                bus0.icap_busy = 1'b1;
                holds--;
            end else begin
                bus0.icap_busy = 1'b0;
                obs0[k] = bus0.icap_i;
                obs1[k] = bus1.icap_i;
                k++;
            end
            cyc++;
            step();
        end
        bus0.icap_busy = 1'b0;
        bus0.set_stb   = 1'b0;
        chk({tag, "_cycles"}, 32'(cyc), 32'(14 + hold_len));
        check_idle({tag, "_end"}, 1'b1);
    endtask

    initial begin
        logic [15:0] golden [14];
        golden = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h0000, 16'h3281, 16'h0B04,
                   16'h32A1, 16'h0000, 16'h32C1, 16'h0B00, 16'h30A1, 16'h000E, 16'h2000};
        bus0.set_stb   = 1'b0;
        bus0.set_addr  = 8'd0;
        bus0.set_data  = 32'd0;
        bus0.icap_busy = 1'b0;
        #2;
        do_reset();
        check_idle("post_reset", 1'b0);

        run_seq("basic", 24'h040000, 24'h000000, -1, 0, -1, -1);
        for (int i = 0; i < 14; i++) chk($sformatf("basic_lit_w%0d", i), 32'(obs0[i]), 32'(golden[i]));
        chk("swap_w1", 32'(obs1[1]), 32'h5599);
        chk("swap_w2", 32'(obs1[2]), 32'hAA66);
        chk("swap_w6", 32'(obs1[6]), 32'hD020);
        chk("swap_w12", 32'(obs1[12]), 32'h0070);

        write(8'd2, 32'hB0070000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("retrig_after_done", 1'b1);
        end

        do_reset();
        write(8'd2, 32'h12340000);
        write(8'd3, 32'hB0070000);
        write(8'd130, 32'hB0070000);
        for (int i = 0; i < 4; i++) begin
            check_idle("bad_trigger", 1'b0);
            step();
        end

        do_reset();
        run_seq("hold4", 24'h040000, 24'h000000, 4, 3, -1, -1);

        do_reset();
        run_seq("inject", 24'($urandom), 24'($urandom), -1, 0, 5, -1);

        do_reset();
        run_seq("abort", 24'($urandom), 24'($urandom), -1, 0, -1, 7);
        for (int i = 0; i < 3; i++) begin
            check_idle("after_abort", 1'b0);
            step();
        end
        run_seq("restart", 24'($urandom), 24'($urandom), -1, 0, -1, -1);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            run_seq($sformatf("rnd%0d", r), 24'($urandom), 24'($urandom),
                    int'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
                    (r % 2 == 0) ? int'($urandom_range(0, 10)) : -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
